vga_pattern_ctrl: RTL and testbench

Frame-synchronous controller that sequences the VGA test pattern generator. It accepts pattern-change requests over a valid/ready handshake and holds each change until the next vertical-blank boundary, so patterns never switch mid-frame. It drives the generator's pattern select and enable and counts frames in the current pattern. It sits between the host/debug control logic and the pattern generator, in the pixel clock domain, alongside the VGA timing generator.

---
 rtl/vga_pattern_ctrl.sv | 135 +++++++++++++
 tb/tb_vga_pattern_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_ctrl.sv
// vga_pattern_ctrl: frame-synchronous sequencer for the VGA test pattern
// generator. Pattern-change requests arrive over a valid/ready handshake and
// are held until the next vertical-blank boundary, so the picture never
// switches mid-frame. Also counts completed frames in the current pattern.
//
// Optional feature macro: VGA_PATTERN_AUTO_CYCLE_EN
//   defined   -> with auto_en=1 the pattern advances every FRAMES_PER_PATTERN
//                frames while running.
//   undefined -> auto_en is ignored; patterns change only through requests.
module vga_pattern_ctrl #(
  parameter int NUM_PATTERNS       = 4,
  parameter int FRAMES_PER_PATTERN = 60,
  parameter int START_PATTERN      = 0
) (
  input  logic        pxl_clk,
  input  logic        pxl_rst_n,
  input  logic        enable,
  input  logic        vert_active,
  input  logic        req_valid,
  input  logic [2:0]  req_pattern,
  output logic        req_ready,
  input  logic        auto_en,
  output logic [2:0]  pattern_sel,
  output logic        pattern_en,
  output logic [15:0] frame_cnt,
  output logic        switch_pulse,
  output logic        req_err
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RUN,
    ST_PEND
  } state_t;

  localparam logic [2:0] START_SEL = 3'(START_PATTERN);
  localparam logic [2:0] LAST_SEL  = 3'(NUM_PATTERNS - 1);
  localparam logic [3:0] NUM_PAT4  = 4'(NUM_PATTERNS);

  state_t      state;
  logic        vert_active_q;
  logic [2:0]  pending;
  logic        frame_end;
  logic        req_fire;
  logic        req_in_range;
  logic [2:0]  next_sel;
  logic [15:0] cnt_inc;
  logic        auto_due;

  // Delay vert_active one cycle so its falling edge marks the start of vblank
  always_ff @(posedge pxl_clk or negedge pxl_rst_n) begin
    if (!pxl_rst_n) vert_active_q <= 1'b0;
    else            vert_active_q <= vert_active;
  end

  assign frame_end    = vert_active_q & ~vert_active;
  assign req_ready    = (state == ST_RUN);
  assign req_fire     = req_valid & req_ready;
  assign req_in_range = ({1'b0, req_pattern} < NUM_PAT4);
  assign next_sel     = (pattern_sel == LAST_SEL) ? 3'd0 : pattern_sel + 3'd1;
  assign cnt_inc      = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;

`ifdef VGA_PATTERN_AUTO_CYCLE_EN
  localparam logic [15:0] LAST_FRAME = 16'(FRAMES_PER_PATTERN - 1);
  assign auto_due = auto_en & (frame_cnt == LAST_FRAME);
`else
  logic unused_cfg;
  assign auto_due   = 1'b0;
  assign unused_cfg = ^{auto_en, 16'(FRAMES_PER_PATTERN)};
`endif

  // Sequencer: OFF waits for a frame boundary, RUN accepts requests and counts
  // frames, PEND holds an accepted request until the next frame boundary
  always_ff @(posedge pxl_clk or negedge pxl_rst_n) begin
    if (!pxl_rst_n) begin
      state        <= ST_OFF;
      pattern_sel  <= START_SEL;
      pattern_en   <= 1'b0;
      frame_cnt    <= 16'd0;
      switch_pulse <= 1'b0;
      req_err      <= 1'b0;
      pending      <= 3'd0;
    end else begin
      switch_pulse <= 1'b0;
      req_err      <= 1'b0;
      if (!enable) begin
        state      <= ST_OFF;
        pattern_en <= 1'b0;
        frame_cnt  <= 16'd0;
      end else begin
        case (state)
          ST_OFF: begin
            if (frame_end) begin
              state      <= ST_RUN;
              pattern_en <= 1'b1;
              frame_cnt  <= 16'd0;
            end
          end
          ST_RUN: begin
            if (req_fire) begin
              if (req_in_range) begin
                pending <= req_pattern;
                state   <= ST_PEND;
              end else begin
                req_err <= 1'b1;
              end
            end
            if (frame_end) begin
              if (auto_due) begin
                pattern_sel  <= next_sel;
                frame_cnt    <= 16'd0;
                switch_pulse <= 1'b1;
              end else begin
                frame_cnt <= cnt_inc;
              end
            end
          end
          ST_PEND: begin
            if (frame_end) begin
              pattern_sel  <= pending;
              frame_cnt    <= 16'd0;
              switch_pulse <= 1'b1;
              state        <= ST_RUN;
            end
          end
          default: begin
            state      <= ST_OFF;
            pattern_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// tb_vga_pattern_ctrl: directed scenarios plus a randomized run against a
// frame-level behavioural model of the pattern controller.
module tb_vga_pattern_ctrl;

  localparam int NP  = 4;
  localparam int FPP = 3;
  localparam int SP  = 0;
`ifdef VGA_PATTERN_AUTO_CYCLE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        pxl_clk;
  logic        pxl_rst_n;
  logic        enable;
  logic        vert_active;
  logic        req_valid;
  logic [2:0]  req_pattern;
  logic        req_ready;
  logic        auto_en;
  logic [2:0]  pattern_sel;
  logic        pattern_en;
  logic [15:0] frame_cnt;
  logic        switch_pulse;
  logic        req_err;
  logic [22:0] dut_out;

  int n_checks;
  int n_fail;

  // Model: generator on/off, selected pattern, frame count, queued request
  bit m_on;
  int m_sel;
  int m_cnt;
  bit m_vq;
  bit m_sw;
  bit m_err;
  int m_pend[$];

  vga_pattern_ctrl #(
    .NUM_PATTERNS(NP),
    .FRAMES_PER_PATTERN(FPP),
    .START_PATTERN(SP)
  ) dut (
    .pxl_clk(pxl_clk),
    .pxl_rst_n(pxl_rst_n),
    .enable(enable),
    .vert_active(vert_active),
    .req_valid(req_valid),
    .req_pattern(req_pattern),
    .req_ready(req_ready),
    .auto_en(auto_en),
    .pattern_sel(pattern_sel),
    .pattern_en(pattern_en),
    .frame_cnt(frame_cnt),
    .switch_pulse(switch_pulse),
    .req_err(req_err)
  );

  assign dut_out = {pattern_en, pattern_sel, frame_cnt, switch_pulse, req_err, req_ready};

  // Free-running pixel clock
  initial pxl_clk = 1'b0;
  always #5 pxl_clk = ~pxl_clk;

  function automatic bit m_ready();
    return m_on && (m_pend.size() == 0);
  endfunction

  function automatic logic [22:0] model_out();
    return {m_on, 3'(m_sel), 16'(m_cnt), m_sw, m_err, m_ready()};
  endfunction

  task automatic model_reset();
    m_on  = 1'b0;
    m_sel = SP;
    m_cnt = 0;
    m_vq  = 1'b0;
    m_sw  = 1'b0;
    m_err = 1'b0;
    m_pend.delete();
  endtask

  // Apply one clock of the behavioural rules to the model using current inputs
  task automatic model_step();
    bit fe;
    fe    = m_vq && !vert_active;
    m_sw  = 1'b0;
    m_err = 1'b0;
    if (!enable) begin
      m_on  = 1'b0;
      m_cnt = 0;
      m_pend.delete();
    end else if (!m_on) begin
      if (fe) begin
        m_on  = 1'b1;
        m_cnt = 0;
      end
    end else if (m_pend.size() != 0) begin
      if (fe) begin
        m_sel = m_pend.pop_front();
        m_cnt = 0;
        m_sw  = 1'b1;
      end
    end else begin
      if (req_valid) begin
        if (int'(req_pattern) < NP) m_pend.push_back(int'(req_pattern));
        else m_err = 1'b1;
      end
      if (fe) begin
        if (AUTO && auto_en && m_cnt == FPP - 1) begin
          m_sel = (m_sel + 1) % NP;
          m_cnt = 0;
          m_sw  = 1'b1;
        end else if (m_cnt < 65535) begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    m_vq = vert_active;
  endtask

  task automatic tick();
    model_step();
    @(posedge pxl_clk);
    #1;
  endtask

  task automatic run(input int n, input logic va);
    vert_active = va;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic end_frame();
    run(3, 1'b1);
    vert_active = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    pxl_rst_n = 1'b0;
    model_reset();
    @(posedge pxl_clk);
    #1;
    pxl_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pxl_rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_out !== {1'b0, 3'(SP), 16'd0, 3'b000}) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got %0h, expected %0h", dut_out, {1'b0, 3'(SP), 16'd0, 3'b000});
    end
    @(posedge pxl_clk);
    #1;
    pxl_rst_n = 1'b1;
  endtask

  task automatic test_startup();
    enable = 1'b1;
    run(4, 1'b1);
    n_checks++;
    if (pattern_en !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL startup_en_before: got %0b, expected 0", pattern_en);
    end
    vert_active = 1'b0;
    tick();
    n_checks++;
    if ({pattern_en, pattern_sel, frame_cnt, req_ready} !== {1'b1, 3'd0, 16'd0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL startup_run: got en=%0b sel=%0d cnt=%0d rdy=%0b, expected 1 0 0 1",
               pattern_en, pattern_sel, frame_cnt, req_ready);
    end
  endtask

  task automatic test_request();
    run(2, 1'b1);
    req_valid = 1'b1;
    req_pattern = 3'd2;
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({req_ready, pattern_sel} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("[TB] FAIL req_accept: got rdy=%0b sel=%0d, expected 0 0", req_ready, pattern_sel);
    end
    run(3, 1'b1);
    n_checks++;
    if ({pattern_sel, switch_pulse} !== {3'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL req_held: got sel=%0d sw=%0b, expected 0 0", pattern_sel, switch_pulse);
    end
    vert_active = 1'b0;
    tick();
    n_checks++;
    if ({pattern_sel, switch_pulse, frame_cnt} !== {3'd2, 1'b1, 16'd0}) begin
      n_fail++;
      $display("[TB] FAIL req_apply: got sel=%0d sw=%0b cnt=%0d, expected 2 1 0",
               pattern_sel, switch_pulse, frame_cnt);
    end
    tick();
    n_checks++;
    if ({switch_pulse, req_ready} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL req_single_pulse: got sw=%0b rdy=%0b, expected 0 1", switch_pulse, req_ready);
    end
  endtask

  task automatic test_same_pattern();
    end_frame();
    run(1, 1'b1);
    req_valid = 1'b1;
    req_pattern = 3'd2;
    tick();
    req_valid = 1'b0;
    end_frame();
    n_checks++;
    if ({pattern_sel, switch_pulse, frame_cnt} !== {3'd2, 1'b1, 16'd0}) begin
      n_fail++;
      $display("[TB] FAIL same_pattern: got sel=%0d sw=%0b cnt=%0d, expected 2 1 0",
               pattern_sel, switch_pulse, frame_cnt);
    end
  endtask

  task automatic test_bad_req();
    run(1, 1'b1);
    req_valid = 1'b1;
    req_pattern = 3'd5;
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({req_err, req_ready, pattern_sel} !== {1'b1, 1'b1, 3'd2}) begin
      n_fail++;
      $display("[TB] FAIL bad_req: got err=%0b rdy=%0b sel=%0d, expected 1 1 2",
               req_err, req_ready, pattern_sel);
    end
    tick();
    n_checks++;
    if ({req_err, req_ready} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL bad_req_pulse: got err=%0b rdy=%0b, expected 0 1", req_err, req_ready);
    end
  endtask

  task automatic test_coincident();
    run(3, 1'b1);
    vert_active = 1'b0;
    req_valid = 1'b1;
    req_pattern = 3'd1;
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({frame_cnt, req_ready, pattern_sel, switch_pulse} !== {16'd1, 1'b0, 3'd2, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL coincident_count: got cnt=%0d rdy=%0b sel=%0d sw=%0b, expected 1 0 2 0",
               frame_cnt, req_ready, pattern_sel, switch_pulse);
    end
    end_frame();
    n_checks++;
    if ({pattern_sel, switch_pulse, frame_cnt} !== {3'd1, 1'b1, 16'd0}) begin
      n_fail++;
      $display("[TB] FAIL coincident_apply: got sel=%0d sw=%0b cnt=%0d, expected 1 1 0",
               pattern_sel, switch_pulse, frame_cnt);
    end
  endtask

  task automatic test_enable_drop();
    run(1, 1'b1);
    req_valid = 1'b1;
    req_pattern = 3'd3;
    tick();
    req_valid = 1'b0;
    enable = 1'b0;
    tick();
    n_checks++;
    if ({pattern_en, frame_cnt, pattern_sel, req_ready} !== {1'b0, 16'd0, 3'd1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL enable_drop: got en=%0b cnt=%0d sel=%0d rdy=%0b, expected 0 0 1 0",
               pattern_en, frame_cnt, pattern_sel, req_ready);
    end
    enable = 1'b1;
    run(3, 1'b1);
    n_checks++;
    if (pattern_en !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL enable_wait: got en=%0b, expected 0", pattern_en);
    end
    vert_active = 1'b0;
    tick();
    n_checks++;
    if ({pattern_en, frame_cnt, pattern_sel, req_ready} !== {1'b1, 16'd0, 3'd1, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL enable_rerun: got en=%0b cnt=%0d sel=%0d rdy=%0b, expected 1 0 1 1",
               pattern_en, frame_cnt, pattern_sel, req_ready);
    end
    end_frame();
    n_checks++;
    if ({pattern_sel, switch_pulse, frame_cnt} !== {3'd1, 1'b0, 16'd1}) begin
      n_fail++;
      $display("[TB] FAIL enable_discard: got sel=%0d sw=%0b cnt=%0d, expected 1 0 1",
               pattern_sel, switch_pulse, frame_cnt);
    end
  endtask

  task automatic test_auto_cycle();
    int exp_sel;
    int exp_cnt;
    bit exp_sw;
    enable = 1'b1;
    do_reset();
    auto_en = 1'b1;
    end_frame();
    for (int k = 1; k <= 15; k++) begin
      end_frame();
      exp_sel = AUTO ? (k / FPP) % NP : SP;
      exp_cnt = AUTO ? k % FPP : k;
      exp_sw  = AUTO && (k % FPP == 0);
      n_checks++;
      if ({pattern_sel, frame_cnt, switch_pulse} !== {3'(exp_sel), 16'(exp_cnt), exp_sw}) begin
        n_fail++;
        $display("[TB] FAIL auto_frame%0d: got sel=%0d cnt=%0d sw=%0b, expected %0d %0d %0b",
                 k, pattern_sel, frame_cnt, switch_pulse, exp_sel, exp_cnt, exp_sw);
      end
    end
    auto_en = 1'b0;
  endtask

  task automatic test_async_reset();
    run(2, 1'b1);
    #2;
    pxl_rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_out !== {1'b0, 3'(SP), 16'd0, 3'b000}) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got %0h, expected %0h", dut_out, {1'b0, 3'(SP), 16'd0, 3'b000});
    end
    @(posedge pxl_clk);
    #1;
    pxl_rst_n = 1'b1;
  endtask

  task automatic test_random();
    int act_len;
    int blank_len;
    int pos;
    bit accepted;
    enable = 1'b1;
    auto_en = 1'b0;
    req_valid = 1'b0;
    do_reset();
    act_len = 4;
    blank_len = 2;
    pos = 0;
    for (int c = 0; c < 3000; c++) begin
      vert_active = (pos < act_len);
      pos++;
      if (pos >= act_len + blank_len) begin
        pos = 0;
        act_len = 2 + int'($urandom_range(6));
        blank_len = 1 + int'($urandom_range(3));
      end
      if ($urandom_range(63) == 0) enable = ~enable;
      if ($urandom_range(127) == 0) auto_en = ~auto_en;
      if (!req_valid && $urandom_range(7) == 0) begin
        req_valid = 1'b1;
        req_pattern = 3'($urandom_range(7));
      end
      accepted = req_valid && m_ready();
      tick();
      n_checks++;
      if (dut_out !== model_out()) begin
        n_fail++;
        $display("[TB] FAIL random_cycle%0d: got %0h, expected %0h", c, dut_out, model_out());
      end
      if (accepted) req_valid = 1'b0;
    end
    req_valid = 1'b0;
  endtask

  // Run the scenarios in order and print the summary
  initial begin
    n_checks = 0;
    n_fail = 0;
    pxl_rst_n = 1'b0;
    enable = 1'b0;
    vert_active = 1'b0;
    req_valid = 1'b0;
    req_pattern = 3'd0;
    auto_en = 1'b0;
    model_reset();
    test_reset();
    test_startup();
    test_request();
    test_same_pattern();
    test_bad_req();
    test_coincident();
    test_enable_drop();
    test_auto_cycle();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
